// File: rtl/stopwatch_ctrl_unit.sv
// Stopwatch control FSM: run/stop/clear sequencing and display-mode selection.
// Define LONG_PRESS_EN to make a long mode press issue a clear and a short press toggle the mode.
module stopwatch_ctrl_unit #(
  parameter int unsigned LONG_PRESS_CYC = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_btn_run,
  input  logic       i_btn_clear,
  input  logic       i_btn_mode,
  output logic       o_run,
  output logic       o_clear,
  output logic       o_mode,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    ST_STOP    = 2'b00,
    ST_RUN     = 2'b01,
    ST_CLEAR   = 2'b10,
    ST_ILLEGAL = 2'b11
  } state_t;

  if (LONG_PRESS_CYC == 0) begin : g_param_check
    $error("LONG_PRESS_CYC must be nonzero");
  end

  state_t state_q, state_d;
  logic   mode_q, mode_d;
  logic   prev_run_q, prev_clear_q, prev_mode_q;
  logic   run_rise, clear_rise;
  logic   mode_evt, long_hit;

  assign run_rise   = i_btn_run & ~prev_run_q;
  assign clear_rise = i_btn_clear & ~prev_clear_q;

`ifdef LONG_PRESS_EN
  localparam int unsigned CW = $clog2(LONG_PRESS_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LONG_PRESS_CYC);

  logic [CW-1:0] hold_q, hold_d;

  always_comb begin
    hold_d = '0;
    if (i_btn_mode) begin
      hold_d = (hold_q == CNT_MAX) ? hold_q : hold_q + 1'b1;
    end
  end

  // Long press fires only on the edge the counter saturates; a saturated count
  // at release also marks the press as long so the fall does not toggle.
  assign long_hit = (hold_q != CNT_MAX) && (hold_d == CNT_MAX);
  assign mode_evt = ~i_btn_mode & prev_mode_q & (hold_q != CNT_MAX);

  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign long_hit = 1'b0;
  assign mode_evt = i_btn_mode & ~prev_mode_q;
`endif

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    case (state_q)
      ST_STOP: begin
        if (clear_rise || long_hit) begin
          state_d = ST_CLEAR;
        end else if (run_rise) begin
          state_d = ST_RUN;
        end
        if (mode_evt) begin
          mode_d = ~mode_q;
        end
      end
      ST_RUN: begin
        if (run_rise) begin
          state_d = ST_STOP;
        end
      end
      ST_CLEAR: state_d = ST_STOP;
      default:  state_d = ST_STOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_STOP;
      mode_q       <= 1'b0;
      prev_run_q   <= 1'b0;
      prev_clear_q <= 1'b0;
      prev_mode_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      prev_run_q   <= i_btn_run;
      prev_clear_q <= i_btn_clear;
      prev_mode_q  <= i_btn_mode;
    end
  end

  assign o_run   = (state_q == ST_RUN);
  assign o_clear = (state_q == ST_CLEAR);
  assign o_mode  = mode_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl_unit.sv
// Directed self-checking bench for stopwatch_ctrl_unit (LONG_PRESS_CYC = 16).
module tb_stopwatch_ctrl_unit;

  logic       clk;
  logic       reset;
  logic       i_btn_run, i_btn_clear, i_btn_mode;
  logic       o_run, o_clear, o_mode;
  logic [1:0] o_state;

  int checks;
  int errors;

  stopwatch_ctrl_unit #(.LONG_PRESS_CYC(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_btn_run  (i_btn_run),
    .i_btn_clear(i_btn_clear),
    .i_btn_mode (i_btn_mode),
    .o_run      (o_run),
    .o_clear    (o_clear),
    .o_mode     (o_mode),
    .o_state    (o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; i_btn_run = 1'b0; i_btn_clear = 1'b0; i_btn_mode = 1'b0;
    tick(); tick();
    checks++; if (o_state !== 2'b00) begin errors++; $display("FAIL reset_state got %b want 00", o_state); end
    checks++; if (o_run !== 1'b0) begin errors++; $display("FAIL reset_run got %b want 0", o_run); end
    checks++; if (o_clear !== 1'b0) begin errors++; $display("FAIL reset_clear got %b want 0", o_clear); end
    checks++; if (o_mode !== 1'b0) begin errors++; $display("FAIL reset_mode got %b want 0", o_mode); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_run_start();
    i_btn_run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (o_run !== 1'b1) begin errors++; $display("FAIL run_start[%0d] o_run got %b want 1", i, o_run); end
      checks++; if (o_state !== 2'b01) begin errors++; $display("FAIL run_start[%0d] o_state got %b want 01", i, o_state); end
    end
    i_btn_run = 1'b0;
    tick();
    checks++; if (o_run !== 1'b1) begin errors++; $display("FAIL run_release o_run got %b want 1", o_run); end
  endtask

  task automatic test_run_stop();
    i_btn_clear = 1'b1;
    tick();
    checks++; if (o_clear !== 1'b0) begin errors++; $display("FAIL clear_in_run o_clear got %b want 0", o_clear); end
    checks++; if (o_state !== 2'b01) begin errors++; $display("FAIL clear_in_run o_state got %b want 01", o_state); end
    i_btn_clear = 1'b0;
    tick();
    tick();
    checks++; if (o_clear !== 1'b0) begin errors++; $display("FAIL clear_in_run_late o_clear got %b want 0", o_clear); end
    i_btn_run = 1'b1;
    tick();
    checks++; if (o_run !== 1'b0) begin errors++; $display("FAIL run_stop o_run got %b want 0", o_run); end
    checks++; if (o_state !== 2'b00) begin errors++; $display("FAIL run_stop o_state got %b want 00", o_state); end
    i_btn_run = 1'b0;
    tick();
  endtask

  task automatic test_clear_wins();
    i_btn_run = 1'b1; i_btn_clear = 1'b1;
    tick();
    checks++; if (o_clear !== 1'b1) begin errors++; $display("FAIL both_clear o_clear got %b want 1", o_clear); end
    checks++; if (o_state !== 2'b10) begin errors++; $display("FAIL both_clear o_state got %b want 10", o_state); end
    checks++; if (o_run !== 1'b0) begin errors++; $display("FAIL both_clear o_run got %b want 0", o_run); end
    tick();
    checks++; if (o_clear !== 1'b0) begin errors++; $display("FAIL both_after o_clear got %b want 0", o_clear); end
    checks++; if (o_state !== 2'b00) begin errors++; $display("FAIL both_after o_state got %b want 00", o_state); end
    tick();
    checks++; if (o_state !== 2'b00) begin errors++; $display("FAIL both_held o_state got %b want 00", o_state); end
    checks++; if (o_run !== 1'b0) begin errors++; $display("FAIL both_held o_run got %b want 0", o_run); end
    i_btn_run = 1'b0; i_btn_clear = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    i_btn_run = 1'b1; tick();
    checks++; if (o_state !== 2'b01) begin errors++; $display("FAIL b2b_start o_state got %b want 01", o_state); end
    i_btn_run = 1'b0; tick();
    i_btn_run = 1'b1; tick();
    checks++; if (o_state !== 2'b00) begin errors++; $display("FAIL b2b_stop o_state got %b want 00", o_state); end
    i_btn_run = 1'b0; tick();
    checks++; if (o_run !== 1'b0) begin errors++; $display("FAIL b2b_idle o_run got %b want 0", o_run); end
  endtask

`ifdef LONG_PRESS_EN
  task automatic test_mode();
    i_btn_mode = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (o_clear !== (i == 15)) begin
        errors++; $display("FAIL long_press[%0d] o_clear got %b want %b", i, o_clear, (i == 15));
      end
    end
    i_btn_mode = 1'b0;
    tick();
    checks++; if (o_mode !== 1'b0) begin errors++; $display("FAIL long_release o_mode got %b want 0", o_mode); end
    checks++; if (o_state !== 2'b00) begin errors++; $display("FAIL long_release o_state got %b want 00", o_state); end
    i_btn_mode = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (o_mode !== 1'b0) begin errors++; $display("FAIL short_held o_mode got %b want 0", o_mode); end
    i_btn_mode = 1'b0;
    tick();
    checks++; if (o_mode !== 1'b1) begin errors++; $display("FAIL short_release o_mode got %b want 1", o_mode); end
    i_btn_run = 1'b1; tick(); i_btn_run = 1'b0; tick();
    i_btn_mode = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (o_clear !== 1'b0) begin errors++; $display("FAIL long_in_run[%0d] o_clear got %b want 0", i, o_clear); end
    end
    i_btn_mode = 1'b0;
    tick();
    i_btn_mode = 1'b1; for (int i = 0; i < 4; i++) tick(); i_btn_mode = 1'b0; tick();
    checks++; if (o_mode !== 1'b1) begin errors++; $display("FAIL mode_in_run o_mode got %b want 1", o_mode); end
    i_btn_run = 1'b1; tick(); i_btn_run = 1'b0; tick();
    checks++; if (o_state !== 2'b00) begin errors++; $display("FAIL back_to_stop o_state got %b want 00", o_state); end
    checks++; if (o_mode !== 1'b1) begin errors++; $display("FAIL not_deferred o_mode got %b want 1", o_mode); end
  endtask
`else
  task automatic test_mode();
    i_btn_mode = 1'b1;
    tick();
    checks++; if (o_mode !== 1'b1) begin errors++; $display("FAIL mode_toggle o_mode got %b want 1", o_mode); end
    tick(); tick();
    checks++; if (o_mode !== 1'b1) begin errors++; $display("FAIL mode_held o_mode got %b want 1", o_mode); end
    i_btn_mode = 1'b0;
    tick();
    i_btn_run = 1'b1; tick(); i_btn_run = 1'b0; tick();
    i_btn_mode = 1'b1;
    tick();
    checks++; if (o_mode !== 1'b1) begin errors++; $display("FAIL mode_in_run o_mode got %b want 1", o_mode); end
    i_btn_mode = 1'b0;
    tick();
    i_btn_run = 1'b1; tick(); i_btn_run = 1'b0; tick();
    checks++; if (o_state !== 2'b00) begin errors++; $display("FAIL back_to_stop o_state got %b want 00", o_state); end
    checks++; if (o_mode !== 1'b1) begin errors++; $display("FAIL not_deferred o_mode got %b want 1", o_mode); end
  endtask
`endif

  task automatic test_reset_mid_run();
    i_btn_run = 1'b1; tick(); i_btn_run = 1'b0; tick();
    checks++; if (o_run !== 1'b1) begin errors++; $display("FAIL pre_reset o_run got %b want 1", o_run); end
    i_btn_mode = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    checks++; if (o_run !== 1'b0) begin errors++; $display("FAIL mid_reset o_run got %b want 0", o_run); end
    checks++; if (o_mode !== 1'b0) begin errors++; $display("FAIL mid_reset o_mode got %b want 0", o_mode); end
    checks++; if (o_clear !== 1'b0) begin errors++; $display("FAIL mid_reset o_clear got %b want 0", o_clear); end
    checks++; if (o_state !== 2'b00) begin errors++; $display("FAIL mid_reset o_state got %b want 00", o_state); end
    reset = 1'b1;
    tick();
`ifdef LONG_PRESS_EN
    checks++; if (o_mode !== 1'b0) begin errors++; $display("FAIL held_release o_mode got %b want 0", o_mode); end
`else
    checks++; if (o_mode !== 1'b1) begin errors++; $display("FAIL held_release o_mode got %b want 1", o_mode); end
`endif
    checks++; if (o_clear !== 1'b0) begin errors++; $display("FAIL held_release o_clear got %b want 0", o_clear); end
    i_btn_mode = 1'b0;
    tick();
    checks++; if (o_mode !== 1'b1) begin errors++; $display("FAIL mode_after_release o_mode got %b want 1", o_mode); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_run_start();
    test_run_stop();
    test_clear_wins();
    test_back_to_back();
    test_mode();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
